fifo_rr_drain: RTL
==================

Name: fifo_rr_drain

Overview:
- Read-side controller for a bank of 4 source FIFOs. It is the consumer of the push/pop FIFO interface.
- Each cycle it observes the FIFO status flags and issues at most one pop, chosen round-robin.
- The popped word is forwarded to a single downstream FIFO, which can stall the block with its almost_full flag.
- Sits between the per-lane FIFO bank and the output FIFO/demux stage.

Parameters:
- DATA_W, 6, width of one data word.
- N_FIFO, 4, number of source FIFOs. Fixed at 4 for this release.
- CNT_W, 8, width of the forwarded-word counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new pops are issued. An in-flight word still completes.
- fifo_empty  input  N_FIFO  empty flag of each source FIFO.
- fifo_almost_empty  input  N_FIFO  almost_empty flag of each source FIFO.
- fifo_data  input  N_FIFO*DATA_W  flattened source data; FIFO i occupies bits [i*DATA_W +: DATA_W]. Valid the cycle after that FIFO's pop.
- out_almost_full  input  1  almost_full flag of the downstream FIFO.
- fifo_pop  output  N_FIFO  one-hot pop strobe; never more than one bit set.
- out_push  output  1  push strobe to the downstream FIFO.
- out_data  output  DATA_W  word being pushed; meaningful only while out_push=1.
- grant_idx  output  2  index of the last FIFO popped.
- idle  output  1  high in the IDLE state.
- word_count  output  CNT_W  total words forwarded; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=1 at a clock edge), values after that edge:
  - fifo_pop=0, out_push=0, out_data=0, grant_idx=3 (so the first grant search starts at FIFO 0), idle=1, word_count=0, state=IDLE.
  - Reset has priority over all other inputs.
  - Reset mid-transfer discards the in-flight word: no out_push is issued and word_count is not incremented.
- Eligibility, for FIFO i in cycle t: eligible when fifo_empty[i]=0 AND NOT (fifo_pop[i] was 1 in cycle t-1 AND fifo_almost_empty[i] was 1 in cycle t-1).
  - This blocks a double-pop caused by the FIFO's one-cycle flag lag.
- Grant: the next grant is the first eligible FIFO scanning grant_idx+1, grant_idx+2, ... modulo 4.
- Pop condition: fifo_pop is combinational from registered state and inputs. It is asserted only when all of the following hold:
  - state is DRAIN;
  - enable=1;
  - out_almost_full=0;
  - reset=0;
  - at least one FIFO is eligible.
- grant_idx updates at the edge ending a pop cycle.
- Latency:
  - Pop in cycle t.
  - The source FIFO drives fifo_data in cycle t+1.
  - The block registers the selected word and asserts out_push=1 with out_data in cycle t+2. Fixed 2-cycle pop-to-push latency.
  - word_count increments at the edge ending each out_push cycle.
- Pipelining: back-to-back pops are allowed, giving sustained 1 word/cycle. Each pop maps to exactly one push, in order.
- Backpressure:
  - out_almost_full=1 blocks new pops from that cycle.
  - Up to 2 in-flight words still push. The downstream almost_full threshold must leave at least 2 free slots.
- State machine:
  - IDLE: move to DRAIN when enable=1 and any fifo_empty bit=0.
  - DRAIN: move to STALL when out_almost_full=1 or enable=0. Move to FLUSH when all FIFOs are ineligible and the pipeline still holds words. Move to IDLE when all FIFOs are ineligible and the pipeline is empty.
  - STALL: no pops; the pipeline drains. Return to DRAIN when out_almost_full=0 and enable=1. Go to IDLE when enable=0 and the pipeline is empty.
  - FLUSH: no pops; wait for in-flight pushes. Return to DRAIN if any FIFO is eligible, otherwise go to IDLE once the pipeline is empty.
- idle=1 only in IDLE with the pipeline empty.
- Simultaneous events: a FIFO becoming non-empty in the same cycle another FIFO is granted does not change the current grant. It is considered on the next scan.

Test Plan:
- Reset, then FIFOs 0..3 each hold 1 word (0x01, 0x12, 0x23, 0x34) -> pops on FIFO 0,1,2,3 in consecutive cycles; out_push in cycles 3..6 with the same data in the same order; word_count=4; idle=1 afterwards.
- Only FIFO 2 non-empty with 3 words and almost_empty low -> fifo_pop=4'b0100 for 3 consecutive cycles, 3 pushes; grant_idx=2.
- FIFO 1 holds 1 word with almost_empty=1 and its empty flag lags one cycle -> exactly one pop and one push; no second pop while fifo_empty[1] still reads 0.
- Continuous traffic; out_almost_full raised for 5 cycles -> pops stop in the same cycle; at most 2 trailing pushes; pops resume the cycle after deassertion with round-robin order preserved.
- reset asserted the cycle after a pop -> no out_push afterwards, word_count=0, grant_idx=3.
- 260 words forwarded -> word_count wraps to 4.

Source files
------------

// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: read-side controller for a bank of source FIFOs.
// Issues at most one pop per cycle, chosen round-robin, and forwards each
// popped word to a downstream FIFO after a fixed two-cycle latency.
module fifo_rr_drain #(
    parameter int DATA_W = 6,
    parameter int N_FIFO = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_FIFO-1:0]        fifo_empty,
    input  logic [N_FIFO-1:0]        fifo_almost_empty,
    input  logic [N_FIFO*DATA_W-1:0] fifo_data,
    input  logic                     out_almost_full,
    output logic [N_FIFO-1:0]        fifo_pop,
    output logic                     out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               grant_idx,
    output logic                     idle,
    output logic [CNT_W-1:0]         word_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        STALL,
        FLUSH
    } drainState;

    drainState          r_state;
    drainState          w_nextState;

    logic [N_FIFO-1:0]  r_popPrev;
    logic [N_FIFO-1:0]  r_aePrev;
    logic [1:0]         r_grantIdx;

    logic               r_s1Valid;
    logic [1:0]         r_s1Idx;
    logic               r_outPush;
    logic [DATA_W-1:0]  r_outData;
    logic [CNT_W-1:0]   r_wordCount;

    logic [N_FIFO-1:0]  w_eligible;
    logic               w_found;
    logic [1:0]         w_nextGrant;
    logic [1:0]         w_cand;
    logic               w_pipeBusy;
    logic               w_popEn;

    // A FIFO popped last cycle while almost empty may still show non-empty
    // because its flags lag by a cycle; hold it off for one cycle.
    assign w_eligible = ~fifo_empty & ~(r_popPrev & r_aePrev);

    // Words popped but not yet pushed downstream.
    assign w_pipeBusy = r_s1Valid | r_outPush;

    // Round-robin search starting just after the last granted FIFO.
    always_comb begin
        w_found     = 1'b0;
        w_nextGrant = r_grantIdx;
        w_cand      = r_grantIdx;
        for (int k = 1; k <= N_FIFO; k++) begin
            w_cand = r_grantIdx + 2'(k);
            if (!w_found && w_eligible[w_cand]) begin
                w_found     = 1'b1;
                w_nextGrant = w_cand;
            end
        end
    end

    assign w_popEn  = (r_state == DRAIN) && enable && !out_almost_full
                      && !reset && w_found;
    assign fifo_pop = w_popEn ? (N_FIFO'(1) << w_nextGrant) : '0;

    // Next-state decision for the drain controller.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (enable && (|(~fifo_empty))) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (out_almost_full || !enable) begin
                    w_nextState = STALL;
                end else if (!w_found) begin
                    w_nextState = w_pipeBusy ? FLUSH : IDLE;
                end
            end
            STALL: begin
                if (!out_almost_full && enable) begin
                    w_nextState = DRAIN;
                end else if (!enable && !w_pipeBusy) begin
                    w_nextState = IDLE;
                end
            end
            FLUSH: begin
                if (w_found) begin
                    w_nextState = DRAIN;
                end else if (!w_pipeBusy) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pop history for the flag-lag guard and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_popPrev  <= '0;
            r_aePrev   <= '0;
            r_grantIdx <= 2'd3;
        end else begin
            r_popPrev <= fifo_pop;
            r_aePrev  <= fifo_almost_empty;
            if (w_popEn) begin
                r_grantIdx <= w_nextGrant;
            end
        end
    end

    // Two-stage pipeline: remember which FIFO was popped, then capture its
    // word the following cycle and present it as a push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Idx   <= '0;
            r_outPush <= 1'b0;
            r_outData <= '0;
        end else begin
            r_s1Valid <= w_popEn;
            r_s1Idx   <= w_nextGrant;
            r_outPush <= r_s1Valid;
            if (r_s1Valid) begin
                r_outData <= fifo_data[r_s1Idx*DATA_W +: DATA_W];
            end
        end
    end

    // Count every forwarded word; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wordCount <= '0;
        end else if (r_outPush) begin
            r_wordCount <= r_wordCount + 1'b1;
        end
    end

    assign out_push   = r_outPush;
    assign out_data   = r_outData;
    assign grant_idx  = r_grantIdx;
    assign idle       = (r_state == IDLE) && !w_pipeBusy;
    assign word_count = r_wordCount;

endmodule
